// File: rtl/tdm_pkg.sv
// Shared definitions for the four-channel TDM transmitter: FSM encoding,
// channel indices and the slot-cycle counter width helper.
package tdm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tdm_state_e;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    // Cycle counter width for a given slot length; a 1-cycle slot still needs a 1-bit counter.
    function automatic int cnt_width(input int slot_len);
        return (slot_len > 1) ? $clog2(slot_len) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot/cycle position within a TDM frame. Advances while running and not held,
// and wraps back to slot 0, cycle 0 after the last cycle of slot 3.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int SLOT_LEN = 1,
    parameter int CNT_W    = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             i_run,
    input  logic             i_hold,
    output logic [1:0]       o_slot,
    output logic [CNT_W-1:0] o_cycle,
    output logic             o_last
);

    logic [1:0]       r_slot;
    logic [CNT_W-1:0] r_cycle;
    logic             w_cycle_end;

    assign w_cycle_end = (r_cycle == CNT_W'(SLOT_LEN - 1));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_slot  <= CH0;
            r_cycle <= '0;
        end else if (i_run && !i_hold) begin
            if (w_cycle_end) begin
                r_cycle <= '0;
                r_slot  <= r_slot + 2'd1;
            end else begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
        end
    end

    assign o_slot  = r_slot;
    assign o_cycle = r_cycle;
    assign o_last  = w_cycle_end && (r_slot == CH3);

endmodule

// File: rtl/tdm_selector41.sv
// Four-channel TDM transmitter: snapshots iD0..iD3 on start and drives them one
// slot at a time onto oZ with a matching {oS1,oS0} select for the distributor.
module tdm_selector41
    import tdm_pkg::*;
#(
    parameter int W        = 1,
    parameter int SLOT_LEN = 1
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic         iHold,
    input  logic [W-1:0] iD0,
    input  logic [W-1:0] iD1,
    input  logic [W-1:0] iD2,
    input  logic [W-1:0] iD3,
    output logic [W-1:0] oZ,
    output logic         oS1,
    output logic         oS0,
    output logic         oValid,
    output logic         oFrame,
    output logic         oBusy,
    output logic         oDone
);

    localparam int CNT_W = cnt_width(SLOT_LEN);

    // state | meaning
    // IDLE  | no frame; outputs low, waiting for iStart
    // SEND  | frame in progress; one channel per slot on oZ

    tdm_state_e       r_state;
    logic [W-1:0]     r_snap [4];
    logic [W-1:0]     r_z;
    logic [1:0]       r_sel;
    logic             r_valid;
    logic             r_frame;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_slot;
    logic [CNT_W-1:0] w_cycle;
    logic             w_last;
    logic [1:0]       w_slot_nxt;

    tdm_slot_counter #(
        .SLOT_LEN (SLOT_LEN),
        .CNT_W    (CNT_W)
    ) u_slot_counter (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .i_run   (r_state == ST_SEND),
        .i_hold  (iHold),
        .o_slot  (w_slot),
        .o_cycle (w_cycle),
        .o_last  (w_last)
    );

    // Outputs are registered, so they are loaded from the slot the counter moves into.
    assign w_slot_nxt = (w_cycle == CNT_W'(SLOT_LEN - 1)) ? w_slot + 2'd1 : w_slot;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            for (int i = 0; i < 4; i++) r_snap[i] <= '0;
            r_z     <= '0;
            r_sel   <= CH0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_state   <= ST_SEND;
                        r_snap[0] <= iD0;
                        r_snap[1] <= iD1;
                        r_snap[2] <= iD2;
                        r_snap[3] <= iD3;
                        r_z       <= iD0;
                        r_sel     <= CH0;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_frame   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!iHold) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                            r_sel  <= CH0;
                            if (iStart) begin
                                r_snap[0] <= iD0;
                                r_snap[1] <= iD1;
                                r_snap[2] <= iD2;
                                r_snap[3] <= iD3;
                                r_z       <= iD0;
                                r_frame   <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_z     <= '0;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_frame <= 1'b0;
                            end
                        end else begin
                            r_done  <= 1'b0;
                            r_frame <= 1'b0;
                            r_z     <= r_snap[w_slot_nxt];
                            r_sel   <= w_slot_nxt;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oZ     = r_z;
    assign oS1    = r_sel[1];
    assign oS0    = r_sel[0];
    assign oValid = r_valid;
    assign oFrame = r_frame;
    assign oBusy  = r_busy;
    assign oDone  = r_done;

endmodule

// File: tb/tb_tdm_selector41.sv
// Directed bench for tdm_selector41: one instance with 1-cycle slots and one
// with 2-cycle slots, both W=4, sharing stimulus; expected values hand-derived.
module tb_tdm_selector41;

    logic       clk = 1'b0;
    logic       rst_n, start, hold;
    logic [3:0] d0, d1, d2, d3;

    logic [3:0] z1, z2;
    logic       s1_1, s0_1, v1, f1, b1, dn1;
    logic       s1_2, s0_2, v2, f2, b2, dn2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdm_selector41 #(.W(4), .SLOT_LEN(1)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iHold(hold),
        .iD0(d0), .iD1(d1), .iD2(d2), .iD3(d3),
        .oZ(z1), .oS1(s1_1), .oS0(s0_1), .oValid(v1), .oFrame(f1),
        .oBusy(b1), .oDone(dn1)
    );

    tdm_selector41 #(.W(4), .SLOT_LEN(2)) u_dut2 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iHold(hold),
        .iD0(d0), .iD1(d1), .iD2(d2), .iD3(d3),
        .oZ(z2), .oS1(s1_2), .oS0(s0_2), .oValid(v2), .oFrame(f2),
        .oBusy(b2), .oDone(dn2)
    );

    // Packed view: {valid, busy, frame, done, sel[1:0], z[3:0]}
    wire [9:0] obs1 = {v1, b1, f1, dn1, s1_1, s0_1, z1};
    wire [9:0] obs2 = {v2, b2, f2, dn2, s1_2, s0_2, z2};

    function automatic logic [9:0] ev(input logic v, input logic b, input logic f,
                                      input logic d, input logic [1:0] s,
                                      input logic [3:0] z);
        return {v, b, f, d, s, z};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got vbfd=%b sel=%b z=%h, expected vbfd=%b sel=%b z=%h",
                     tag, obs[9:6], obs[5:4], obs[3:0], exp[9:6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] ed  [4];
    logic [3:0] ed2 [4];

    initial begin
        // 1: reset with every input active
        rst_n = 1'b0; start = 1'b1; hold = 1'b1;
        d0 = 4'h9; d1 = 4'h9; d2 = 4'h9; d3 = 4'h9;
        tick(); tick();
        chk("rst dut1", obs1, 10'd0);
        chk("rst dut2", obs2, 10'd0);
        rst_n = 1'b1; start = 1'b0; hold = 1'b0;
        tick();
        chk("rst release dut1", obs1, 10'd0);
        chk("rst release dut2", obs2, 10'd0);

        // 2: SLOT_LEN=1 single frame
        ed[0] = 4'hA; ed[1] = 4'h5; ed[2] = 4'hC; ed[3] = 4'h3;
        d0 = ed[0]; d1 = ed[1]; d2 = ed[2]; d3 = ed[3];
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("t2 slot%0d", i), obs1,
                ev(1'b1, 1'b1, i == 0, 1'b0, 2'(i), ed[i]));
        end
        tick();
        chk("t2 done", obs1, ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0));
        tick();
        chk("t2 idle", obs1, 10'd0);

        // 3: SLOT_LEN=2, inputs change after the start edge
        do_reset();
        d0 = ed[0]; d1 = ed[1]; d2 = ed[2]; d3 = ed[3];
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            d0 = 4'hF; d1 = 4'hF; d2 = 4'hF; d3 = 4'hF;
            chk($sformatf("t3 cyc%0d", i), obs2,
                ev(1'b1, 1'b1, i == 0, 1'b0, 2'(i / 2), ed[i / 2]));
        end
        tick();
        chk("t3 done", obs2, ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0));
        tick();
        chk("t3 idle", obs2, 10'd0);

        // 4: start held high gives back-to-back frames with a fresh snapshot
        do_reset();
        ed[0] = 4'h1; ed[1] = 4'h2; ed[2] = 4'h3; ed[3] = 4'h4;
        ed2[0] = 4'h5; ed2[1] = 4'h6; ed2[2] = 4'h7; ed2[3] = 4'h8;
        d0 = ed[0]; d1 = ed[1]; d2 = ed[2]; d3 = ed[3];
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                d0 = ed2[0]; d1 = ed2[1]; d2 = ed2[2]; d3 = ed2[3];
            end
            if (i == 8) start = 1'b0;
            chk($sformatf("t4 cyc%0d", i), obs2,
                ev(1'b1, 1'b1, (i % 8) == 0, i == 8, 2'((i % 8) / 2),
                   (i < 8) ? ed[(i % 8) / 2] : ed2[(i % 8) / 2]));
        end
        tick();
        chk("t4 done", obs2, ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0));

        // 5: hold for 3 cycles in slot 2, start during hold ignored
        do_reset();
        ed[0] = 4'hA; ed[1] = 4'h5; ed[2] = 4'hC; ed[3] = 4'h3;
        d0 = ed[0]; d1 = ed[1]; d2 = ed[2]; d3 = ed[3];
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
        end
        chk("t5 slot2", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'hC));
        hold = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5 hold%0d", i), obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'hC));
        end
        hold = 1'b0; start = 1'b0;
        tick();
        chk("t5 slot2c1", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'hC));
        tick(); tick();
        chk("t5 slot3", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'h3));
        tick();
        chk("t5 late done", obs2, ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0));
        tick();
        chk("t5 no queued start", obs2, 10'd0);
        hold = 1'b1; start = 1'b1;
        tick();
        chk("t5 hold in idle", obs2, ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA));
        hold = 1'b0; start = 1'b0;

        // 6: reset during slot 1 aborts without a done pulse
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t6 slot1", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h5));
        rst_n = 1'b0;
        tick();
        chk("t6 abort", obs2, 10'd0);
        rst_n = 1'b1;
        tick();
        chk("t6 no done a", obs2, 10'd0);
        tick();
        chk("t6 no done b", obs2, 10'd0);
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        start = 1'b1;
        tick();
        chk("t6 restart", obs2, ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1));
        start = 1'b0;
        tick();
        chk("t6 restart c1", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h1));
        tick();
        chk("t6 restart s1", obs2, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_selector41.md
Name: tdm_selector41

Overview:
- Four-channel time-division multiplexer: the transmit end of the link whose receive end is the 1-to-4 data distributor (de_selector14).
- On a start request it snapshots four W-bit input channels, then drives them one at a time onto a single output bus.
- It drives the matching 2-bit channel select, so a downstream distributor can steer each slot back to output Z0..Z3.
- Sits between the channel sources and the shared serial path in the 6.2 selector/distributor experiment.

Parameters:
W, 1, width of each data channel and of oZ
SLOT_LEN, 1, clock cycles each channel occupies on the bus (legal range 1..16)

Ports:
iClk  input  1  rising-edge clock
iRst_n  input  1  synchronous reset, active-low
iStart  input  1  frame request; sampled only when a new frame may begin
iHold  input  1  pause; freezes an in-progress frame
iD0  input  W  channel 0 data
iD1  input  W  channel 1 data
iD2  input  W  channel 2 data
iD3  input  W  channel 3 data
oZ  output  W  multiplexed data, registered
oS1  output  1  channel select MSB, registered
oS0  output  1  channel select LSB, registered
oValid  output  1  high while oZ carries a slot
oFrame  output  1  high during the first cycle of slot 0 only
oBusy  output  1  high while a frame is in progress
oDone  output  1  one-cycle pulse after a frame completes

Behaviour:
- Clock and reset:
  - Single clock iClk.
  - iRst_n is synchronous and active-low, sampled on the rising edge of iClk.
- Reset values: state IDLE, slot=0, cycle=0, snapshot=0, and every output 0 (oZ=0, oS1=oS0=0, oValid=oBusy=oFrame=oDone=0).
- States: IDLE and SEND.
- IDLE:
  - At an edge where iStart=1: capture iD0..iD3 into the snapshot, go to SEND with slot=0 and cycle=0.
  - Outputs after that edge: oValid=1, oBusy=1, oFrame=1, {oS1,oS0}=00, oZ=snapshot0.
  - Latency: start sampled at edge k, first slot visible after edge k.
- SEND, with iHold=0, each edge:
  - If cycle<SLOT_LEN-1: cycle+1.
  - Otherwise cycle=0 and slot+1.
  - oZ=snapshot[slot], {oS1,oS0}=slot; oFrame is high only for slot=0, cycle=0.
- Frame end: the last cycle is slot=3, cycle=SLOT_LEN-1. At the edge that ends it:
  - oDone=1 for exactly one cycle.
  - If iStart=1: recapture iD0..iD3 and begin slot 0 immediately. No idle gap; oFrame=1 and oDone=1 in the same cycle; oBusy stays 1.
  - If iStart=0: go to IDLE. oValid=0, oBusy=0, oZ=0, oS=00.
- iStart during SEND other than the last cycle: ignored, not queued.
- iHold=1 in SEND:
  - slot, cycle and all outputs hold their values (oFrame and oDone included).
  - An iStart on that edge is ignored.
  - iHold in IDLE has no effect; a start still proceeds.
- Snapshot: input changes during a frame do not affect the data being sent.
- Reset mid-frame: the frame is aborted immediately and no oDone pulse occurs.
- Total frame length with no holds is 4*SLOT_LEN cycles.

Decomposition:
- Shared package tdm_pkg holds:
  - state encoding (IDLE=0, SEND=1);
  - localparam CNT_W = clog2(SLOT_LEN), minimum 1;
  - channel-index constants CH0..CH3 = 2'd0..2'd3.
- One natural sub-module, tdm_slot_counter:
  - cycle/slot counter with hold input;
  - outputs slot, cycle and a last-cycle flag.
- Mux, snapshot and FSM stay in the top module.

Test Plan:
1. Reset: iRst_n=0 for 2 cycles with all inputs active -> every output 0; release with iStart=0 -> outputs remain 0.
2. W=4, SLOT_LEN=1, iD0..iD3 = 4'hA, 4'h5, 4'hC, 4'h3, iStart pulsed one cycle:
   - next 4 cycles show oZ=A,5,C,3 and oS=00,01,10,11;
   - oFrame high in cycle 1 only;
   - oDone high one cycle afterwards, oBusy low.
3. SLOT_LEN=2, iD inputs changed to 4'hF after the start edge -> each value held 2 cycles; the original snapshot values are sent; frame lasts 8 cycles.
4. iStart held high -> frames back to back, oBusy never drops; oFrame and oDone coincide at each frame boundary; new snapshot values appear in the second frame.
5. iHold=1 for 3 cycles during slot 2 -> oZ and oS frozen at slot 2; the frame ends exactly 3 cycles late; an iStart during the hold is ignored.
6. iRst_n=0 during slot 1 -> next cycle all outputs 0, no oDone pulse; a later iStart begins a fresh frame at slot 0.
